// File: rtl/load_store_unit_pkg.sv
// rtl/load_store_unit_pkg.sv - memory access encodings, LSU state type and shared access helpers
package load_store_unit_pkg;

  localparam logic [2:0] MEM_BYTE              = 3'b000;
  localparam logic [2:0] MEM_HALFWORD          = 3'b001;
  localparam logic [2:0] MEM_WORD              = 3'b010;
  localparam logic [2:0] MEM_BYTE_UNSIGNED     = 3'b100;
  localparam logic [2:0] MEM_HALFWORD_UNSIGNED = 3'b101;

  typedef enum logic {
    LSU_IDLE,
    LSU_SPLIT
  } lsu_state_t;

  // Right-aligned raw data extended according to the access size and signedness.
  function automatic logic [31:0] mem_extend(input logic [2:0] control, input logic [31:0] raw);
    case (control)
      MEM_BYTE:              return {{24{raw[7]}}, raw[7:0]};
      MEM_HALFWORD:          return {{16{raw[15]}}, raw[15:0]};
      MEM_BYTE_UNSIGNED:     return {24'h000000, raw[7:0]};
      MEM_HALFWORD_UNSIGNED: return {16'h0000, raw[15:0]};
      default:               return raw;
    endcase
  endfunction

  function automatic logic is_misaligned(input logic [2:0] control, input logic [1:0] addr_lo);
    case (control)
      MEM_HALFWORD, MEM_HALFWORD_UNSIGNED: return addr_lo[0];
      MEM_WORD:                            return addr_lo != 2'b00;
      default:                             return 1'b0;
    endcase
  endfunction

  // Index of the final byte of a split access (k-1).
  function automatic logic [1:0] split_last(input logic [2:0] control);
    return (control == MEM_WORD) ? 2'd3 : 2'd1;
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// rtl/load_store_unit_if.sv - pipeline request and memory data-port bundle around the LSU
interface load_store_unit_if;

  logic        Req_Valid;
  logic        Req_W_En;
  logic [2:0]  Req_Control;
  logic [31:0] Req_Addr;
  logic [31:0] Req_W_Data;
  logic        Stall_LSU;
  logic        MEM_W_En;
  logic [2:0]  MEM_Control;
  logic [31:0] RW_Addr;
  logic [31:0] W_Data;
  logic [31:0] R_Data;
  logic        Load_Valid;
  logic [31:0] Load_Data;

  // Pipeline plus memory side of the LSU.
  modport master (
    output Req_Valid, Req_W_En, Req_Control, Req_Addr, Req_W_Data, R_Data,
    input  Stall_LSU, MEM_W_En, MEM_Control, RW_Addr, W_Data, Load_Valid, Load_Data
  );

  modport slave (
    input  Req_Valid, Req_W_En, Req_Control, Req_Addr, Req_W_Data, R_Data,
    output Stall_LSU, MEM_W_En, MEM_Control, RW_Addr, W_Data, Load_Valid, Load_Data
  );

endinterface

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - passes aligned accesses through, splits misaligned ones into byte accesses
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             RST,
  load_store_unit_if.slave bus,
  output logic [CNT_W-1:0] Misalign_Count
);

  lsu_state_t  state, state_next;
  logic [1:0]  idx, idx_next;
  logic [1:0]  last_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [2:0]  ctrl_q;
  logic        store_q;
  logic [23:0] byte_buf;
  logic        load_finish;
  logic        aligned_load_q;

  logic        start_split;
  logic        final_issue;
  logic        mem_w_en;
  logic        stall;
  logic [7:0]  split_byte;
  logic [31:0] split_raw;

  assign start_split = (state == LSU_IDLE) && bus.Req_Valid
                       && is_misaligned(bus.Req_Control, bus.Req_Addr[1:0]);
  assign final_issue = (state == LSU_SPLIT) && (idx == last_q);

  always_comb begin
    split_byte = wdata_q[7:0];
    case (idx)
      2'd1:    split_byte = wdata_q[15:8];
      2'd2:    split_byte = wdata_q[23:16];
      2'd3:    split_byte = wdata_q[31:24];
      default: split_byte = wdata_q[7:0];
    endcase
  end

  always_comb begin
    state_next      = state;
    idx_next        = idx;
    mem_w_en        = 1'b0;
    stall           = 1'b0;
    bus.MEM_Control = bus.Req_Control;
    bus.RW_Addr     = bus.Req_Addr;
    bus.W_Data      = bus.Req_W_Data;
    case (state)
      LSU_IDLE: begin
        if (start_split) begin
          mem_w_en        = bus.Req_W_En;
          stall           = 1'b1;
          bus.MEM_Control = MEM_BYTE_UNSIGNED;
          bus.W_Data      = {24'h000000, bus.Req_W_Data[7:0]};
          state_next      = LSU_SPLIT;
          idx_next        = 2'd1;
        end else begin
          mem_w_en = bus.Req_Valid & bus.Req_W_En;
        end
      end
      LSU_SPLIT: begin
        mem_w_en        = store_q;
        stall           = (idx != last_q);
        bus.MEM_Control = MEM_BYTE_UNSIGNED;
        bus.RW_Addr     = addr_q + {30'd0, idx};
        bus.W_Data      = {24'h000000, split_byte};
        idx_next        = idx + 2'd1;
        if (idx == last_q) begin
          state_next = LSU_IDLE;
          idx_next   = 2'd0;
        end
      end
      default: begin
        state_next = LSU_IDLE;
        idx_next   = 2'd0;
      end
    endcase
  end

  // Reset also silences the memory port so an abandoned split writes nothing further.
  assign bus.MEM_W_En   = RST & mem_w_en;
  assign bus.Stall_LSU  = RST & stall;
  assign bus.Load_Valid = RST & (load_finish | aligned_load_q);

  // The last byte of a split load arrives directly from memory; earlier ones come from the buffer.
  assign split_raw = (ctrl_q == MEM_WORD) ? {bus.R_Data[7:0], byte_buf}
                                          : {16'h0000, bus.R_Data[7:0], byte_buf[7:0]};

  always_comb begin
    bus.Load_Data = 32'h0;
    if (RST) begin
      if (load_finish)         bus.Load_Data = mem_extend(ctrl_q, split_raw);
      else if (aligned_load_q) bus.Load_Data = bus.R_Data;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state          <= LSU_IDLE;
      idx            <= 2'd0;
      last_q         <= 2'd0;
      addr_q         <= 32'h0;
      wdata_q        <= 32'h0;
      ctrl_q         <= 3'b000;
      store_q        <= 1'b0;
      byte_buf       <= 24'h0;
      load_finish    <= 1'b0;
      aligned_load_q <= 1'b0;
      Misalign_Count <= '0;
    end else begin
      state          <= state_next;
      idx            <= idx_next;
      load_finish    <= final_issue && !store_q;
      aligned_load_q <= (state == LSU_IDLE) && bus.Req_Valid && !bus.Req_W_En && !start_split;
      if (start_split) begin
        addr_q  <= bus.Req_Addr;
        wdata_q <= bus.Req_W_Data;
        ctrl_q  <= bus.Req_Control;
        store_q <= bus.Req_W_En;
        last_q  <= split_last(bus.Req_Control);
        if (Misalign_Count != '1)
          Misalign_Count <= Misalign_Count + {{(CNT_W-1){1'b0}}, 1'b1};
      end
      // While issuing byte idx, memory returns byte idx-1.
      if (state == LSU_SPLIT && !store_q) begin
        case (idx)
          2'd1:    byte_buf[7:0]   <= bus.R_Data[7:0];
          2'd2:    byte_buf[15:8]  <= bus.R_Data[7:0];
          2'd3:    byte_buf[23:16] <= bus.R_Data[7:0];
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - directed and random checks of load_store_unit against a byte-level memory model
module tb_load_store_unit;
  import load_store_unit_pkg::*;

  logic       CLK = 1'b0;
  logic       RST;
  logic [1:0] cnt;
  int         checks = 0;
  int         errors = 0;
  int         exp_cnt = 0;

  always #5 CLK = ~CLK;

  load_store_unit_if bus();

  load_store_unit #(.CNT_W(2)) dut (
    .CLK            (CLK),
    .RST            (RST),
    .bus            (bus.slave),
    .Misalign_Count (cnt)
  );

  logic [7:0] mem [256];
  logic [7:0] ref_mem [logic [31:0]];

  function automatic logic [31:0] ext(input logic [2:0] c, input logic [31:0] raw);
    case (c)
      3'b000:  return {{24{raw[7]}}, raw[7:0]};
      3'b001:  return {{16{raw[15]}}, raw[15:0]};
      3'b100:  return {24'h0, raw[7:0]};
      3'b101:  return {16'h0, raw[15:0]};
      default: return raw;
    endcase
  endfunction

  function automatic int nbytes(input logic [2:0] c);
    if (c[1:0] == 2'b00) return 1;
    if (c[1:0] == 2'b01) return 2;
    return 4;
  endfunction

  function automatic logic [7:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : 8'h00;
  endfunction

  // Emulated memory: the port does its own lane selection and extension, synchronous read.
  always @(posedge CLK) begin
    if (bus.MEM_W_En) begin
      mem[bus.RW_Addr[7:0]] <= bus.W_Data[7:0];
      if (nbytes(bus.MEM_Control) >= 2) mem[bus.RW_Addr[7:0] + 8'd1] <= bus.W_Data[15:8];
      if (nbytes(bus.MEM_Control) == 4) begin
        mem[bus.RW_Addr[7:0] + 8'd2] <= bus.W_Data[23:16];
        mem[bus.RW_Addr[7:0] + 8'd3] <= bus.W_Data[31:24];
      end
    end
    bus.R_Data <= ext(bus.MEM_Control, {mem[bus.RW_Addr[7:0] + 8'd3], mem[bus.RW_Addr[7:0] + 8'd2],
                                        mem[bus.RW_Addr[7:0] + 8'd1], mem[bus.RW_Addr[7:0]]});
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Entered and left at posedge+1.
  task automatic issue(input logic we, input logic [2:0] c, input logic [31:0] a, input logic [31:0] d);
    int          sz;
    bit          mis;
    int          k;
    logic [31:0] exp_ld;
    sz  = nbytes(c);
    mis = (sz == 2 && a[0]) || (sz == 4 && a[1:0] != 2'b00);
    k   = mis ? sz : 1;
    exp_ld = ext(c, {ref_rd(a + 32'd3), ref_rd(a + 32'd2), ref_rd(a + 32'd1), ref_rd(a)});
    if (we) for (int i = 0; i < sz; i++) ref_mem[a + 32'(i)] = d[8*i +: 8];
    bus.Req_Valid   = 1'b1;
    bus.Req_W_En    = we;
    bus.Req_Control = c;
    bus.Req_Addr    = a;
    bus.Req_W_Data  = d;
    for (int j = 0; j < k; j++) begin
      @(negedge CLK);
      chk("stall", 32'(bus.Stall_LSU), 32'(mis && j < k - 1));
      chk("rw_addr", bus.RW_Addr, mis ? a + 32'(j) : a);
      chk("mem_w_en", 32'(bus.MEM_W_En), 32'(we));
      if (mis) chk("mem_control", 32'(bus.MEM_Control), 32'(MEM_BYTE_UNSIGNED));
      if (mis && we) chk("w_byte", 32'(bus.W_Data[7:0]), 32'(d[8*j +: 8]));
      if (mis && j == 0 && exp_cnt < 3) exp_cnt++;
      @(posedge CLK); #1;
    end
    bus.Req_Valid = 1'b0;
    bus.Req_W_En  = 1'b0;
    @(negedge CLK);
    chk("stall_after", 32'(bus.Stall_LSU), 32'd0);
    chk("load_valid", 32'(bus.Load_Valid), 32'(!we));
    if (!we) chk("load_data", bus.Load_Data, exp_ld);
    chk("misalign_count", 32'(cnt), 32'(exp_cnt));
    @(posedge CLK); #1;
  endtask

  initial begin
    logic [2:0] ld_ctrl [5];
    logic [31:0] a;
    logic [31:0] d;
    logic [2:0]  c;
    ld_ctrl = '{MEM_BYTE, MEM_HALFWORD, MEM_WORD, MEM_BYTE_UNSIGNED, MEM_HALFWORD_UNSIGNED};
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    RST             = 1'b0;
    bus.Req_Valid   = 1'b0;
    bus.Req_W_En    = 1'b0;
    bus.Req_Control = MEM_WORD;
    bus.Req_Addr    = 32'h0;
    bus.Req_W_Data  = 32'h0;

    // Reset state
    @(posedge CLK); #1;
    @(negedge CLK);
    chk("rst_stall", 32'(bus.Stall_LSU), 32'd0);
    chk("rst_w_en", 32'(bus.MEM_W_En), 32'd0);
    chk("rst_load_valid", 32'(bus.Load_Valid), 32'd0);
    chk("rst_load_data", bus.Load_Data, 32'd0);
    @(posedge CLK); #1;
    RST = 1'b1;
    @(negedge CLK);
    chk("rst_count", 32'(cnt), 32'd0);
    chk("idle_w_en", 32'(bus.MEM_W_En), 32'd0);
    @(posedge CLK); #1;

    // Aligned store/load
    issue(1'b1, MEM_WORD, 32'h4, 32'hFBBFFAAF);
    issue(1'b0, MEM_WORD, 32'h4, 32'h0);
    chk("aligned_word_ref", {ref_rd(32'h7), ref_rd(32'h6), ref_rd(32'h5), ref_rd(32'h4)}, 32'hFBBFFAAF);

    // Misaligned word store then load
    issue(1'b1, MEM_WORD, 32'h5, 32'hFBBFFAAF);
    issue(1'b0, MEM_WORD, 32'h5, 32'h0);

    // Misaligned halfword store, signed and unsigned loads
    issue(1'b1, MEM_HALFWORD, 32'h3, 32'h0000F00F);
    issue(1'b0, MEM_HALFWORD, 32'h3, 32'h0);
    issue(1'b0, MEM_HALFWORD_UNSIGNED, 32'h3, 32'h0);

    // Wrap-around
    issue(1'b0, MEM_WORD, 32'hFFFF_FFFE, 32'h0);

    // Reset in the middle of a split store at 0x9
    issue(1'b1, MEM_WORD, 32'h8, 32'h11223344);
    issue(1'b1, MEM_WORD, 32'hC, 32'h55667788);
    bus.Req_Valid   = 1'b1;
    bus.Req_W_En    = 1'b1;
    bus.Req_Control = MEM_WORD;
    bus.Req_Addr    = 32'h9;
    bus.Req_W_Data  = 32'hA1B2C3D4;
    @(negedge CLK);
    chk("rs_addr0", bus.RW_Addr, 32'h9);
    @(posedge CLK); #1;
    @(negedge CLK);
    chk("rs_addr1", bus.RW_Addr, 32'hA);
    @(posedge CLK); #1;
    RST = 1'b0;
    @(negedge CLK);
    chk("rs_w_en_in_reset", 32'(bus.MEM_W_En), 32'd0);
    chk("rs_stall_in_reset", 32'(bus.Stall_LSU), 32'd0);
    @(posedge CLK); #1;
    RST = 1'b1;
    bus.Req_Valid = 1'b0;
    bus.Req_W_En  = 1'b0;
    ref_mem[32'h9] = 8'hD4;
    ref_mem[32'hA] = 8'hC3;
    exp_cnt = 0;
    @(negedge CLK);
    chk("rs_stall_after", 32'(bus.Stall_LSU), 32'd0);
    chk("rs_w_en_after", 32'(bus.MEM_W_En), 32'd0);
    chk("rs_count", 32'(cnt), 32'd0);
    @(posedge CLK); #1;
    for (int i = 9; i <= 12; i++) issue(1'b0, MEM_BYTE_UNSIGNED, 32'(i), 32'h0);

    // Saturating counter with a 2-bit width: 1, 2, 3, 3, 3
    for (int i = 0; i < 5; i++) issue(1'b0, MEM_HALFWORD, 32'h21 + 32'(2 * i), 32'h0);
    chk("count_saturated", 32'(cnt), 32'd3);

    // Random mix of loads and stores near the bottom of memory and across the wrap point
    for (int n = 0; n < 60; n++) begin
      a = ($urandom_range(0, 4) == 0) ? 32'hFFFF_FFF0 + 32'($urandom_range(0, 15))
                                      : 32'($urandom_range(0, 47));
      d = $urandom;
      if ($urandom_range(0, 1) == 1) begin
        c = ld_ctrl[$urandom_range(0, 2)];
        issue(1'b1, c, a, d);
      end else begin
        c = ld_ctrl[$urandom_range(0, 4)];
        issue(1'b0, c, a, 32'h0);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
